// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the parametrised data memory.
package dmem_pkg;

   localparam int DMEM_STATE_W = 2;

   typedef enum logic [DMEM_STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } dmem_state_e;

   function automatic int dmem_be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Index width into the storage array; at least one bit for DEPTH=1.
   function automatic int DMEM_IDX_W(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Zero-initialised word storage with per-byte write enables and a registered read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int  DATA_W = 16,
   parameter int  DEPTH  = 256,
   localparam int BE_W   = dmem_be_w(DATA_W),
   localparam int IDX_W  = DMEM_IDX_W(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_param.sv
// Handshaked data memory with configurable wait states and out-of-range error responses.
// Optional DMEM_ERR_COUNT_EN adds a saturating 8-bit error-response counter output.
module data_memory_param
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   input  logic [DATA_W/8-1:0]    req_be,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err
`ifdef DMEM_ERR_COUNT_EN
   ,output logic [7:0]            err_count
`endif
);

   localparam int IDX_W = DMEM_IDX_W(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int CMP_W = (ADDR_W > 32) ? ADDR_W + 1 : 33;

   dmem_state_e       state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              lat_we, lat_err;
   logic              accept, in_range;
   logic [DATA_W-1:0] arr_rdata;

   // Full-width compare so high address bits can never alias into the array.
   assign in_range = CMP_W'(req_addr) < CMP_W'(DEPTH);
   assign accept   = req_ready & req_valid & ~rst;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (accept & req_we & in_range),
      .be    (req_be),
      .re    (accept & ~req_we & in_range),
      .addr  (req_addr[IDX_W-1:0]),
      .wdata (req_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
         end
         S_WAIT: if (cnt + CNT_W'(1) == CNT_W'(WAIT_CYCLES)) state_nxt = S_RESP;
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The response registers load as RESP is left, giving the one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= (state == S_RESP);
         if (accept) begin
            cnt     <= '0;
            lat_we  <= req_we;
            lat_err <= ~in_range;
         end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (state == S_RESP) begin
            rsp_err   <= lat_err;
            rsp_rdata <= (lat_we || lat_err) ? '0 : arr_rdata;
         end
      end
   end

`ifdef DMEM_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (state == S_RESP && lat_err && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: doc/data_memory_param.md
Name: data_memory_param

Overview:
- Parametrised, handshaked data memory. Next generation of the team's 16-bit data memory.
- Adds configurable width and depth, per-byte write enables, and a configurable number of access wait states.
- Returns a one-cycle response pulse for every request, with an error flag for out-of-range addresses.
- Sits between the CPU load/store stage and storage; the pipeline stalls on req_ready.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words.
- ADDR_W, 16, request address width; word-addressed.
- WAIT_CYCLES, 1, extra cycles between accept and response; 0 is legal.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH; valid with rsp_valid.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE, wait counter to 0.
  - req_ready=1 is visible after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory contents are not cleared by rst; they are zero only at time-0 initialisation.
- FSM state IDLE:
  - req_ready=1.
  - Accept when req_valid=1 at posedge. Latch we, addr and be.
  - On accept, go to WAIT if WAIT_CYCLES>0, else to RESP.
- FSM state WAIT:
  - req_ready=0.
  - Counter counts 1..WAIT_CYCLES, then goes to RESP.
- FSM state RESP:
  - req_ready=0, rsp_valid=1 for exactly one cycle, then back to IDLE.
- Latency:
  - Accept at edge N gives rsp_valid high during the cycle after edge N+1+WAIT_CYCLES.
  - Throughput is one request per WAIT_CYCLES+2 cycles.
- Writes:
  - Committed at the accept edge. Byte i is written only if req_be[i]=1.
  - The response carries rsp_rdata=0.
  - be=0 is a legal no-op write that still responds.
- Reads:
  - Data sampled from the array at the accept edge; no wait-state re-read.
  - rsp_rdata is held from RESP until the next RESP, then zeroed on the next response cycle if write/error.
- Out of range (latched addr >= DEPTH):
  - No array access; the write is dropped.
  - Response has rsp_rdata=0 and rsp_err=1.
  - Address bits above $clog2(DEPTH) are never silently wrapped.
- Reset mid-operation:
  - rst in WAIT or RESP aborts the access. No rsp_valid for that request.
  - An already-accepted write stays committed.
- Inputs are ignored while req_ready=0. No request queueing.
- The wait counter width is max(1, $clog2(WAIT_CYCLES+1)).

Optional Feature:
- Macro: DMEM_ERR_COUNT_EN.
- Defined:
  - Adds output err_count, 8 bits, reset to 0.
  - Increments on each rsp_valid with rsp_err=1 and saturates at 8'hFF.
- Undefined:
  - The port and counter are absent. All other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP) and its width constant;
  - localparam helpers BE_W=DATA_W/8 and a DMEM_IDX_W function ($clog2(DEPTH)).
- One sub-module, dmem_array:
  - storage with a per-byte write-enable port and a synchronous read port;
  - zero initialised;
  - parameters DATA_W and DEPTH.
- The FSM, counter and response registers stay in data_memory_param.

Test Plan (defaults: DATA_W=16, DEPTH=256, WAIT_CYCLES=1):
- Write addr 0x0001, data 0x1234, be=2'b11, then read 0x0001 → the read shows rsp_valid two edges after accept, rdata=0x1234, err=0.
- Write addr 0x0001, data 0xABCD, be=2'b01, then read 0x0001 → rdata=0x12CD.
- Read uninitialised addr 0x00FF → rdata=0x0000, err=0.
- Write 0x5555 to addr 0x0100, then read 0x0000 → write response has err=1 and rdata=0; read returns the previous value with err=0.
- Hold req_valid=1 for 6 cycles → req_ready pattern 1,0,0,1,0,0; exactly two accepts, two single-cycle rsp_valid pulses.
- Assert rst in WAIT after a read accept → no rsp_valid; req_ready=1 the cycle after reset deasserts. Repeat with WAIT_CYCLES=0 → response one edge after accept.
